// File: rtl/pl_cpu_core.sv
// pl_cpu_core: 5-stage in-order RV32I-subset CPU (IF, ID, EX, MEM, WB) with
// internal instruction memory, data memory and register file.
// Ports:
//   clk - system clock, all state changes on the rising edge
//   rst - synchronous active-high reset (PC=0, pipeline bubbles, regs cleared)
// Internal hierarchy: instruction_mem.mem, data_mem.mem, rf.regs.
// Optional build macro PLCPU_HALT_EN: fetch stops when the fetch PC reaches
// END_PC; the pipeline drains and the core idles until reset.

// Word-addressed instruction store; combinational read, boot-load write port.
module pl_cpu_imem #(parameter int DEPTH = 1024, parameter int AW = 10) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:DEPTH-1];
  assign rdata = mem[addr];
  // Boot-load write port (tied off inside the core).
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// Word-addressed data store; combinational read, rising-edge write.
module pl_cpu_dmem #(parameter int DEPTH = 1024, parameter int AW = 10) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:DEPTH-1];
  assign rdata = mem[addr];
  // Store write; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// 32x32 register file; x0 hardwired to zero, same-cycle write bypassed to reads.
module pl_cpu_rf (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [0:31];
  // Reset clears every register; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end
  // A write landing this cycle is visible to ID ("write first half").
  assign rd1 = (ra1 == 5'd0) ? 32'h0 : ((we && (wa == ra1)) ? wd : regs[ra1]);
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : ((we && (wa == ra2)) ? wd : regs[ra2]);
endmodule

module pl_cpu_core #(
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [31:0] END_PC     = 32'h84
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_REG: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  endfunction

  logic [31:0] pc_r, ifid_pc_r, ifid_inst_r, imem_data_s;
  logic        ifid_valid_r, fetch_en_s, load_use_s, redirect_s, br_taken_s;
  logic [31:0] idex_pc_r, idex_a_r, idex_b_r, idex_imm_r;
  logic [6:0]  idex_op_r;
  logic [2:0]  idex_f3_r;
  logic        idex_valid_r, idex_f7b_r;
  logic [4:0]  idex_rd_r, idex_rs1_r, idex_rs2_r;
  logic        exmem_valid_r, exmem_wr_r, exmem_ld_r, exmem_st_r;
  logic [4:0]  exmem_rd_r, memwb_rd_r;
  logic [31:0] exmem_res_r, exmem_sd_r, memwb_wd_r, dmem_rdata_s;
  logic        memwb_valid_r, memwb_wr_r;
  logic [6:0]  id_op_s;
  logic [31:0] id_imm_s, rf_a_s, rf_b_s, fwd_a_s, fwd_b_s, op_b_s, alu_s, ex_res_s, target_s;
  logic        use_rs1_s, use_rs2_s;

  pl_cpu_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) instruction_mem (
    .clk(clk), .we(1'b0), .addr(pc_r[IAW+1:2]), .wdata(32'h0), .rdata(imem_data_s));

  pl_cpu_dmem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) data_mem (
    .clk(clk), .we(exmem_valid_r && exmem_st_r && !rst), .addr(exmem_res_r[DAW+1:2]),
    .wdata(exmem_sd_r), .rdata(dmem_rdata_s));

  pl_cpu_rf rf (
    .clk(clk), .rst(rst), .ra1(ifid_inst_r[19:15]), .ra2(ifid_inst_r[24:20]),
    .rd1(rf_a_s), .rd2(rf_b_s), .we(memwb_valid_r && memwb_wr_r && !rst),
    .wa(memwb_rd_r), .wd(memwb_wd_r));

`ifdef PLCPU_HALT_EN
  assign fetch_en_s = (pc_r != END_PC);
`else
  assign fetch_en_s = 1'b1;
`endif

  // ---------------- ID: decode, immediate, load-use detection ----------------
  assign id_op_s   = ifid_inst_r[6:0];
  assign use_rs1_s = !((id_op_s == OP_LUI) || (id_op_s == OP_AUIPC) || (id_op_s == OP_JAL));
  assign use_rs2_s = (id_op_s == OP_REG) || (id_op_s == OP_ST) || (id_op_s == OP_BR);
  assign load_use_s = ifid_valid_r && idex_valid_r && (idex_op_r == OP_LD) && (idex_rd_r != 5'd0) &&
                      ((use_rs1_s && (ifid_inst_r[19:15] == idex_rd_r)) ||
                       (use_rs2_s && (ifid_inst_r[24:20] == idex_rd_r)));

  // Immediate generation by instruction format.
  always_comb begin
    case (id_op_s)
      OP_ST:           id_imm_s = {{20{ifid_inst_r[31]}}, ifid_inst_r[31:25], ifid_inst_r[11:7]};
      OP_BR:           id_imm_s = {{19{ifid_inst_r[31]}}, ifid_inst_r[31], ifid_inst_r[7],
                                   ifid_inst_r[30:25], ifid_inst_r[11:8], 1'b0};
      OP_LUI, OP_AUIPC: id_imm_s = {ifid_inst_r[31:12], 12'h000};
      OP_JAL:          id_imm_s = {{11{ifid_inst_r[31]}}, ifid_inst_r[31], ifid_inst_r[19:12],
                                   ifid_inst_r[20], ifid_inst_r[30:21], 1'b0};
      default:         id_imm_s = {{20{ifid_inst_r[31]}}, ifid_inst_r[31:20]};
    endcase
  end

  // ---------------- EX: forwarding (younger stage wins), ALU, branch ----------------
  // rd==0 never sets exmem_wr_r/memwb_wr_r, so x0 is never forwarded.
  always_comb begin
    if (exmem_valid_r && exmem_wr_r && (exmem_rd_r == idex_rs1_r))      fwd_a_s = exmem_res_r;
    else if (memwb_valid_r && memwb_wr_r && (memwb_rd_r == idex_rs1_r)) fwd_a_s = memwb_wd_r;
    else                                                                fwd_a_s = idex_a_r;
  end

  // Same forwarding network for the rs2 operand.
  always_comb begin
    if (exmem_valid_r && exmem_wr_r && (exmem_rd_r == idex_rs2_r))      fwd_b_s = exmem_res_r;
    else if (memwb_valid_r && memwb_wr_r && (memwb_rd_r == idex_rs2_r)) fwd_b_s = memwb_wd_r;
    else                                                                fwd_b_s = idex_b_r;
  end

  assign op_b_s = (idex_op_r == OP_REG) ? fwd_b_s : idex_imm_r;

  // ALU; loads, stores and jalr fall through to the address adder.
  always_comb begin
    alu_s = fwd_a_s + op_b_s;
    if ((idex_op_r == OP_REG) || (idex_op_r == OP_IMM)) begin
      case (idex_f3_r)
        3'b000:  alu_s = ((idex_op_r == OP_REG) && idex_f7b_r) ? (fwd_a_s - op_b_s) : (fwd_a_s + op_b_s);
        3'b001:  alu_s = fwd_a_s << op_b_s[4:0];
        3'b010:  alu_s = {31'h0, ($signed(fwd_a_s) < $signed(op_b_s))};
        3'b011:  alu_s = {31'h0, (fwd_a_s < op_b_s)};
        3'b100:  alu_s = fwd_a_s ^ op_b_s;
        3'b101:  alu_s = idex_f7b_r ? $unsigned($signed(fwd_a_s) >>> op_b_s[4:0]) : (fwd_a_s >> op_b_s[4:0]);
        3'b110:  alu_s = fwd_a_s | op_b_s;
        default: alu_s = fwd_a_s & op_b_s;
      endcase
    end else begin
      alu_s = fwd_a_s + op_b_s;
    end
  end

  // Branch condition; unsupported funct3 codes never take.
  always_comb begin
    case (idex_f3_r)
      3'b000:  br_taken_s = (fwd_a_s == fwd_b_s);
      3'b001:  br_taken_s = (fwd_a_s != fwd_b_s);
      3'b100:  br_taken_s = ($signed(fwd_a_s) < $signed(fwd_b_s));
      3'b101:  br_taken_s = ($signed(fwd_a_s) >= $signed(fwd_b_s));
      default: br_taken_s = 1'b0;
    endcase
  end

  // Value carried to MEM/WB for register-writing instructions.
  always_comb begin
    case (idex_op_r)
      OP_LUI:          ex_res_s = idex_imm_r;
      OP_AUIPC:        ex_res_s = idex_pc_r + idex_imm_r;
      OP_JAL, OP_JALR: ex_res_s = idex_pc_r + 32'd4;
      default:         ex_res_s = alu_s;
    endcase
  end

  assign redirect_s = idex_valid_r && ((idex_op_r == OP_JAL) || (idex_op_r == OP_JALR) ||
                                       ((idex_op_r == OP_BR) && br_taken_s));
  assign target_s   = (idex_op_r == OP_JALR) ? (alu_s & 32'hFFFF_FFFE) : (idex_pc_r + idex_imm_r);

  // PC and IF/ID: redirect beats stall; a stall or halt holds the fetch PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r         <= 32'h0;
      ifid_valid_r <= 1'b0;
    end else if (redirect_s) begin
      pc_r         <= target_s;
      ifid_valid_r <= 1'b0;
    end else if (!load_use_s) begin
      if (fetch_en_s) pc_r <= pc_r + 32'd4;
      ifid_valid_r <= fetch_en_s;
      ifid_pc_r    <= pc_r;
      ifid_inst_r  <= imem_data_s;
    end
  end

  // ID/EX: bubble on reset, redirect flush or load-use stall.
  always_ff @(posedge clk) begin
    idex_valid_r <= !(rst || redirect_s || load_use_s) && ifid_valid_r;
    idex_pc_r    <= ifid_pc_r;
    idex_a_r     <= rf_a_s;
    idex_b_r     <= rf_b_s;
    idex_imm_r   <= id_imm_s;
    idex_op_r    <= id_op_s;
    idex_f3_r    <= ifid_inst_r[14:12];
    idex_f7b_r   <= ifid_inst_r[30];
    idex_rd_r    <= ifid_inst_r[11:7];
    idex_rs1_r   <= ifid_inst_r[19:15];
    idex_rs2_r   <= ifid_inst_r[24:20];
  end

  // EX/MEM and MEM/WB registers; unknown opcodes carry no side effects.
  always_ff @(posedge clk) begin
    exmem_valid_r <= !rst && idex_valid_r;
    exmem_wr_r    <= writes_rd(idex_op_r) && (idex_rd_r != 5'd0);
    exmem_ld_r    <= (idex_op_r == OP_LD);
    exmem_st_r    <= (idex_op_r == OP_ST);
    exmem_rd_r    <= idex_rd_r;
    exmem_res_r   <= ex_res_s;
    exmem_sd_r    <= fwd_b_s;
    memwb_valid_r <= !rst && exmem_valid_r;
    memwb_wr_r    <= exmem_wr_r;
    memwb_rd_r    <= exmem_rd_r;
    memwb_wd_r    <= exmem_ld_r ? dmem_rdata_s : exmem_res_r;
  end
endmodule

// File: tb/tb_pl_cpu_core.sv
// Directed self-checking bench for pl_cpu_core. Programs are written straight
// into the instruction memory array; results are read from rf.regs/data_mem.mem.
module tb_pl_cpu_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   wp;

  pl_cpu_core dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    logic [11:0] im; logic [4:0] a, d; logic [2:0] f;
    im = imm[11:0]; a = rs1[4:0]; d = rd[4:0]; f = f3[2:0];
    return {im, a, f, d, op};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [6:0] g; logic [4:0] a, b, d; logic [2:0] f;
    g = f7[6:0]; b = rs2[4:0]; a = rs1[4:0]; d = rd[4:0]; f = f3[2:0];
    return {g, b, a, f, d, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [11:0] im; logic [4:0] a, b;
    im = imm[11:0]; a = rs1[4:0]; b = rs2[4:0];
    return {im[11:5], b, a, 3'b010, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [12:0] im; logic [4:0] a, b; logic [2:0] f;
    im = imm[12:0]; a = rs1[4:0]; b = rs2[4:0]; f = f3[2:0];
    return {im[12], im[10:5], b, a, f, im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
    logic [19:0] im; logic [4:0] d;
    im = imm20[19:0]; d = rd[4:0];
    return {im, d, op};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] im; logic [4:0] d;
    im = imm[20:0]; d = rd[4:0];
    return {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) dut.instruction_mem.mem[i] = 32'h0;
    wp = 0;
  endtask
  task automatic put(input logic [31:0] w);
    dut.instruction_mem.mem[wp] = w;
    wp++;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_alu_prog();
    clear_imem();
    put(enc_i(5, 0, 0, 1, 7'h13));      // addi x1,x0,5
    put(enc_i(7, 0, 0, 2, 7'h13));      // addi x2,x0,7
    put(enc_r(0, 2, 1, 0, 3));          // add  x3,x1,x2
    put(enc_s(0, 3, 0));                // sw   x3,0(x0)
    put(enc_i(0, 0, 2, 4, 7'h03));      // lw   x4,0(x0)
    put(enc_i(1, 4, 0, 5, 7'h13));      // addi x5,x4,1
    put(enc_j(0, 0));                   // jal  x0,0
  endtask

  task automatic load_loop_prog();
    clear_imem();
    put(enc_i(0, 0, 0, 6, 7'h13));      // addi x6,x0,0
    put(enc_i(0, 0, 0, 7, 7'h13));      // addi x7,x0,0
    put(enc_i(10, 0, 0, 8, 7'h13));     // addi x8,x0,10
    put(enc_i(1, 7, 0, 7, 7'h13));      // 0x0C: addi x7,x7,1
    put(enc_r(0, 7, 6, 0, 6));          // add  x6,x6,x7
    put(enc_b(-8, 8, 7, 1));            // bne  x7,x8,0x0C
    put(enc_j(0, 0));                   // jal  x0,0
  endtask

  task automatic loop_final_checks(input string pfx);
    // Last add retires at edge 5+31+18 = 54 after release (9 taken branches).
    step(53);
    check_value({pfx, "_x6_before"}, dut.rf.regs[6], 32'd45);
    step(1);
    check_value({pfx, "_x6_sum"}, dut.rf.regs[6], 32'd55);
    check_value({pfx, "_x7_count"}, dut.rf.regs[7], 32'd10);
  endtask

  initial begin
    // Reset state.
    load_alu_prog();
    dut.data_mem.mem[0] = 32'h0;
    do_reset();
    check_value("rst_pc", dut.pc_r, 32'h0);
    check_value("rst_x1", dut.rf.regs[1], 32'h0);
    check_value("rst_x31", dut.rf.regs[31], 32'h0);
    check_value("rst_valids", {28'h0, dut.ifid_valid_r, dut.idex_valid_r, dut.exmem_valid_r, dut.memwb_valid_r}, 32'h0);

    // ALU with back-to-back forwarding: add is instr 2, retires at edge 7.
    step(6);
    check_value("alu_x3_early", dut.rf.regs[3], 32'h0);
    step(1);
    check_value("alu_x3", dut.rf.regs[3], 32'd12);
    check_value("alu_x1", dut.rf.regs[1], 32'd5);
    check_value("alu_x2", dut.rf.regs[2], 32'd7);
    check_value("alu_x0", dut.rf.regs[0], 32'h0);

    // Load-use: addi x5 (instr 5) retires at edge 10 + 1 stall = 11.
    step(3);
    check_value("lu_x5_stall", dut.rf.regs[5], 32'h0);
    step(1);
    check_value("lu_x5", dut.rf.regs[5], 32'd13);
    check_value("lu_x4", dut.rf.regs[4], 32'd12);
    check_value("lu_dmem0", dut.data_mem.mem[0], 32'd12);

    // Branch loop summing 1..10.
    load_loop_prog();
    do_reset();
    loop_final_checks("loop");

    // Nested loop, 3 x 4 increments, ending at 0x84.
    clear_imem();
    put(enc_i(0, 0, 0, 10, 7'h13));     // addi x10,x0,0
    put(enc_i(3, 0, 0, 11, 7'h13));     // addi x11,x0,3
    put(enc_i(4, 0, 0, 12, 7'h13));     // 0x08: addi x12,x0,4
    put(enc_i(1, 10, 0, 10, 7'h13));    // 0x0C: addi x10,x10,1
    put(enc_i(-1, 12, 0, 12, 7'h13));   // addi x12,x12,-1
    put(enc_b(-8, 0, 12, 1));           // bne x12,x0,0x0C
    put(enc_i(-1, 11, 0, 11, 7'h13));   // addi x11,x11,-1
    put(enc_b(-20, 0, 11, 1));          // bne x11,x0,0x08
    while (wp < 33) put(enc_i(0, 0, 0, 0, 7'h13));
    put(enc_i(99, 0, 0, 9, 7'h13));     // 0x84: addi x9,x0,99
    put(enc_j(0, 0));                   // jal x0,0
    do_reset();
    step(150);
    check_value("nest_count", dut.rf.regs[10], 32'd12);
    check_value("nest_outer", dut.rf.regs[11], 32'd0);
`ifdef PLCPU_HALT_EN
    check_value("halt_pc", dut.pc_r, 32'h84);
    check_value("halt_x9", dut.rf.regs[9], 32'd0);
    step(20);
    check_value("halt_pc_hold", dut.pc_r, 32'h84);
`else
    check_value("nohalt_x9", dut.rf.regs[9], 32'd99);
`endif

    // lui / jal / jalr with flushed shadow instructions.
    clear_imem();
    put(enc_u(32'h12345, 7, 7'h37));    // 0x00: lui x7,0x12345
    put(enc_j(16, 1));                  // 0x04: jal x1,0x14
    put(enc_i(5, 0, 0, 21, 7'h13));     // 0x08: addi x21,x0,5
    put(enc_j(0, 0));                   // 0x0C: jal x0,0
    put(enc_i(66, 0, 0, 22, 7'h13));    // 0x10: addi x22,x0,66
    put(enc_i(7, 0, 0, 23, 7'h13));     // 0x14: addi x23,x0,7
    put(enc_i(1, 1, 0, 0, 7'h67));      // 0x18: jalr x0,1(x1)
    put(enc_i(77, 0, 0, 24, 7'h13));    // 0x1C
    put(enc_i(88, 0, 0, 25, 7'h13));    // 0x20
    do_reset();
    step(40);
    check_value("jmp_lui", dut.rf.regs[7], 32'h1234_5000);
    check_value("jmp_link", dut.rf.regs[1], 32'h0000_0008);
    check_value("jmp_ret_path", dut.rf.regs[21], 32'd5);
    check_value("jmp_sub", dut.rf.regs[23], 32'd7);
    check_value("jmp_skip_x22", dut.rf.regs[22], 32'd0);
    check_value("jmp_skip_x24", dut.rf.regs[24], 32'd0);
    check_value("jmp_skip_x25", dut.rf.regs[25], 32'd0);

    // Mid-run reset during the summing loop, then rerun.
    load_loop_prog();
    do_reset();
    step(30);
    rst = 1'b1;
    step(1);
    check_value("mid_pc", dut.pc_r, 32'h0);
    check_value("mid_x6", dut.rf.regs[6], 32'h0);
    check_value("mid_x7", dut.rf.regs[7], 32'h0);
    rst = 1'b0;
    loop_final_checks("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
